// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store sequencer.
package mau_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam int unsigned HALF_W = 2 * LANE_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mau_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } mau_state_t;

    // Size code 2'b11 is reserved and behaves as a word.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SZ_HALF) && lane[0]) || (is_word(size) && (lane != 2'd0));
    endfunction

endpackage

// File: rtl/mau_lane_unit.sv
// Byte-lane extract/extend for loads and lane merge for stores (little-endian).
module mau_lane_unit
    import mau_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              sign_ext,
    input  logic [WORD_W-1:0] word_in,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data_c,
    output logic [WORD_W-1:0] store_word_c
);

    logic [LANE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    always_comb begin
        byte_sel = word_in[LANE_W-1:0];
        case (lane)
            2'd1:    byte_sel = word_in[2*LANE_W-1:LANE_W];
            2'd2:    byte_sel = word_in[3*LANE_W-1:2*LANE_W];
            2'd3:    byte_sel = word_in[4*LANE_W-1:3*LANE_W];
            default: byte_sel = word_in[LANE_W-1:0];
        endcase
        half_sel = lane[1] ? word_in[WORD_W-1:HALF_W] : word_in[HALF_W-1:0];

        load_data_c = word_in;
        case (size)
            SZ_BYTE: load_data_c = {{(WORD_W-LANE_W){sign_ext & byte_sel[LANE_W-1]}}, byte_sel};
            SZ_HALF: load_data_c = {{(WORD_W-HALF_W){sign_ext & half_sel[HALF_W-1]}}, half_sel};
            default: load_data_c = word_in;
        endcase
    end

    // Replace only the addressed lanes of the previously read word.
    always_comb begin
        store_word_c = word_in;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd1:    store_word_c[2*LANE_W-1:LANE_W]        = wdata[LANE_W-1:0];
                    2'd2:    store_word_c[3*LANE_W-1:2*LANE_W]      = wdata[LANE_W-1:0];
                    2'd3:    store_word_c[4*LANE_W-1:3*LANE_W]      = wdata[LANE_W-1:0];
                    default: store_word_c[LANE_W-1:0]               = wdata[LANE_W-1:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) store_word_c[WORD_W-1:HALF_W] = wdata[HALF_W-1:0];
                else         store_word_c[HALF_W-1:0]      = wdata[HALF_W-1:0];
            end
            default: store_word_c = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: word-wide memory cycles, RMW for sub-word stores, load extension.
// Optional misaligned-access trap enabled by defining MAU_MISALIGN_TRAP_EN.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    mau_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              trap_c;
    logic [DATA_W-1:0] lane_word_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] store_word_c;

`ifdef MAU_MISALIGN_TRAP_EN
    assign trap_c = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap_c = 1'b0;
`endif

    // Extract straight from memory during RD; merge against the captured word during WR.
    assign lane_word_c = (state_q == RD) ? mem_read_data : rd_q;

    mau_lane_unit u_lane (
        .size         (size_q),
        .lane         (addr_q[1:0]),
        .sign_ext     (signed_q),
        .word_in      (lane_word_c),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        rd_d         = rd_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    if (trap_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_write && is_word(req_size)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            RD: begin
                rd_d = mem_read_data;
                if (write_q) begin
                    state_d = WR;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data_c;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            rd_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            rd_q         <= rd_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    // Memory strobes decode from state so an async reset drops them at once.
    assign mem_read       = (state_q == RD);
    assign mem_write      = (state_q == WR);
    assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_write_data = (state_q == WR) ? store_word_c : '0;

endmodule
